// File: rtl/spi_scene_loader.sv
// SPI scene loader: parses 64-bit SPI words into scene RAM writes,
// commit requests and full-scene clears, with timeout and error status.
// Ports: CLK100MHZ/ck_rst_ clock and async active-low reset;
//   recv_dv/recv_64bit incoming word strobe and data;
//   frame_busy defers commit while the raytracer renders;
//   recv_interrupt flow control to the MCU (high = ready for a word);
//   scene_wr_en/scene_wr_addr/scene_wr_data scene RAM write port;
//   commit one-cycle swap pulse; err sticky {overrun, timeout, bad header}.
module spi_scene_loader #(
   parameter int OBJ_AW         = 4,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic              CLK100MHZ,
   input  logic              ck_rst_,
   input  logic              recv_dv,
   input  logic [63:0]       recv_64bit,
   input  logic              frame_busy,
   output logic              recv_interrupt,
   output logic              scene_wr_en,
   output logic [OBJ_AW:0]   scene_wr_addr,
   output logic [63:0]       scene_wr_data,
   output logic              commit,
   output logic [2:0]        err
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [2:0] {
      IDLE,
      PAYLOAD0,
      PAYLOAD1,
      WAIT_SWAP,
      CLEARING
   } state_t;

   state_t              state;
   logic [OBJ_AW-1:0]   obj_idx;
   logic [OBJ_AW:0]     clr_addr;
   logic [TW-1:0]       to_cnt;

   logic [7:0] hdr_sync;
   logic [3:0] hdr_op;
   logic [7:0] hdr_idx;
   logic       sync_ok;
   logic       idx_ok;
   logic       is_write;
   logic       is_commit;
   logic       is_clear;

   assign hdr_sync  = recv_64bit[63:56];
   assign hdr_op    = recv_64bit[55:52];
   assign hdr_idx   = recv_64bit[47:40];
   assign sync_ok   = (hdr_sync == 8'hA5);
   // index bits above the object range must be zero
   assign idx_ok    = ((hdr_idx >> OBJ_AW) == 8'd0);
   assign is_write  = sync_ok && (hdr_op == 4'd1) && idx_ok;
   assign is_commit = sync_ok && (hdr_op == 4'd2);
   assign is_clear  = sync_ok && (hdr_op == 4'd3);

   always_ff @(posedge CLK100MHZ or negedge ck_rst_) begin
      if (!ck_rst_) begin
         state          <= IDLE;
         obj_idx        <= '0;
         clr_addr       <= '0;
         to_cnt         <= '0;
         recv_interrupt <= 1'b1;
         scene_wr_en    <= 1'b0;
         scene_wr_addr  <= '0;
         scene_wr_data  <= '0;
         commit         <= 1'b0;
         err            <= 3'b000;
      end else begin
         scene_wr_en <= 1'b0;
         commit      <= 1'b0;
         unique case (state)
            IDLE: begin
               if (recv_dv) begin
                  unique case (1'b1)
                     is_write: begin
                        obj_idx <= hdr_idx[OBJ_AW-1:0];
                        to_cnt  <= '0;
                        state   <= PAYLOAD0;
                     end
                     is_commit: begin
                        recv_interrupt <= 1'b0;
                        state          <= WAIT_SWAP;
                     end
                     is_clear: begin
                        // address 0 is written on entry so the
                        // zero writes line up with the busy window
                        recv_interrupt <= 1'b0;
                        scene_wr_en    <= 1'b1;
                        scene_wr_addr  <= '0;
                        scene_wr_data  <= '0;
                        clr_addr       <= (OBJ_AW+1)'(1);
                        state          <= CLEARING;
                     end
                     default: err[0] <= 1'b1;
                  endcase
               end
            end
            PAYLOAD0, PAYLOAD1: begin
               if (recv_dv) begin
                  scene_wr_en   <= 1'b1;
                  scene_wr_addr <= {obj_idx, state == PAYLOAD1};
                  scene_wr_data <= recv_64bit;
                  to_cnt        <= '0;
                  state         <= (state == PAYLOAD0) ? PAYLOAD1 : IDLE;
               end else if (to_cnt == TO_LAST) begin
                  err[1] <= 1'b1;
                  to_cnt <= '0;
                  state  <= IDLE;
               end else begin
                  to_cnt <= to_cnt + TW'(1);
               end
            end
            WAIT_SWAP: begin
               if (recv_dv) err[2] <= 1'b1;
               if (!frame_busy) begin
                  commit         <= 1'b1;
                  recv_interrupt <= 1'b1;
                  state          <= IDLE;
               end
            end
            CLEARING: begin
               if (recv_dv) err[2] <= 1'b1;
               // counter wrapped back to 0: every address written
               if (clr_addr == '0) begin
                  err            <= 3'b000;
                  recv_interrupt <= 1'b1;
                  state          <= IDLE;
               end else begin
                  scene_wr_en   <= 1'b1;
                  scene_wr_addr <= clr_addr;
                  scene_wr_data <= '0;
                  clr_addr      <= clr_addr + (OBJ_AW+1)'(1);
               end
            end
            default: begin
               recv_interrupt <= 1'b1;
               state          <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_spi_scene_loader.sv
// Self-checking bench for spi_scene_loader: header table, timed
// corner sequences and a randomized run against a scene-array model.
module tb_spi_scene_loader;

   logic        clk = 1'b0;
   logic        ck_rst_ = 1'b0;
   logic        recv_dv = 1'b0;
   logic [63:0] recv_64bit = '0;
   logic        frame_busy = 1'b0;
   logic        recv_interrupt;
   logic        scene_wr_en;
   logic [4:0]  scene_wr_addr;
   logic [63:0] scene_wr_data;
   logic        commit;
   logic [2:0]  err;

   spi_scene_loader #(.OBJ_AW(4), .TIMEOUT_CYCLES(100)) dut (
      .CLK100MHZ     (clk),
      .ck_rst_       (ck_rst_),
      .recv_dv       (recv_dv),
      .recv_64bit    (recv_64bit),
      .frame_busy    (frame_busy),
      .recv_interrupt(recv_interrupt),
      .scene_wr_en   (scene_wr_en),
      .scene_wr_addr (scene_wr_addr),
      .scene_wr_data (scene_wr_data),
      .commit        (commit),
      .err           (err)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   int wr_cnt = 0;
   int commit_cnt = 0;
   int ovl_cnt = 0;
   logic [63:0] act_mem [32];
   logic [63:0] exp_mem [32];

   always @(negedge clk) begin
      if (ck_rst_) begin
         if (scene_wr_en) begin
            act_mem[scene_wr_addr] = scene_wr_data;
            wr_cnt++;
         end
         if (commit) commit_cnt++;
         if (scene_wr_en && commit) ovl_cnt++;
      end
   end

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input logic [63:0] w);
      recv_dv    = 1'b1;
      recv_64bit = w;
      @(posedge clk);
      #1;
      recv_dv = 1'b0;
   endtask

   task automatic do_reset();
      ck_rst_    = 1'b0;
      recv_dv    = 1'b0;
      frame_busy = 1'b0;
      idle(2);
      ck_rst_ = 1'b1;
      idle(1);
   endtask

   function automatic logic [63:0] hdr(input logic [3:0] op,
                                       input logic [7:0] idx);
      return {8'hA5, op, 4'h0, idx, 40'h0};
   endfunction

   typedef struct {
      logic [63:0] h;
      logic [63:0] p0;
      logic [63:0] p1;
      logic [2:0]  exp_err;
      logic        exp_wr;
      logic [4:0]  exp_addr;
   } vec_t;

   vec_t vt[8];

   initial begin
      int          w0, c0, hi;
      logic [63:0] w;
      logic [2:0]  exp_err;
      int          exp_wn, exp_cn;

      vt[0] = '{hdr(4'd1, 8'h00), 64'h1, 64'h2, 3'b000, 1'b1, 5'd0};
      vt[1] = '{64'hA51F_0F12_3456_789A, 64'hAB, 64'hCD, 3'b000, 1'b1, 5'd30};
      vt[2] = '{hdr(4'd1, 8'h10), 64'h0, 64'h0, 3'b001, 1'b0, 5'd0};
      vt[3] = '{hdr(4'd1, 8'hFF), 64'h0, 64'h0, 3'b001, 1'b0, 5'd0};
      vt[4] = '{hdr(4'd0, 8'h01), 64'h0, 64'h0, 3'b001, 1'b0, 5'd0};
      vt[5] = '{hdr(4'd4, 8'h01), 64'h0, 64'h0, 3'b001, 1'b0, 5'd0};
      vt[6] = '{64'hA410_0500_0000_0000, 64'h0, 64'h0, 3'b001, 1'b0, 5'd0};
      vt[7] = '{hdr(4'd1, 8'h07), hdr(4'd1, 8'h03), 64'h77, 3'b000,
                1'b1, 5'd14};

      // reset state
      do_reset();
      chk("rst_rint", recv_interrupt, 1'b1);
      chk("rst_wren", scene_wr_en, 1'b0);
      chk("rst_addr", scene_wr_addr, 5'd0);
      chk("rst_data", scene_wr_data, 64'h0);
      chk("rst_commit", commit, 1'b0);
      chk("rst_err", err, 3'b000);

      // header table
      for (int i = 0; i < 8; i++) begin
         do_reset();
         w0 = wr_cnt;
         send(vt[i].h);
         chk($sformatf("tbl%0d_err", i), err, vt[i].exp_err);
         chk($sformatf("tbl%0d_hwr", i), scene_wr_en, 1'b0);
         if (vt[i].exp_wr) begin
            send(vt[i].p0);
            chk($sformatf("tbl%0d_w0", i),
                {scene_wr_en, scene_wr_addr, scene_wr_data},
                {1'b1, vt[i].exp_addr, vt[i].p0});
            send(vt[i].p1);
            chk($sformatf("tbl%0d_w1", i),
                {scene_wr_en, scene_wr_addr, scene_wr_data},
                {1'b1, vt[i].exp_addr + 5'd1, vt[i].p1});
         end else begin
            idle(3);
            chk($sformatf("tbl%0d_nowr", i), wr_cnt - w0, 0);
            chk($sformatf("tbl%0d_rint", i), recv_interrupt, 1'b1);
         end
      end

      // basic write to object 3
      do_reset();
      send(64'hA510_0300_0000_0000);
      send(64'h1111);
      chk("obj3_w0", {scene_wr_en, scene_wr_addr, scene_wr_data},
          {1'b1, 5'd6, 64'h1111});
      send(64'h2222);
      chk("obj3_w1", {scene_wr_en, scene_wr_addr, scene_wr_data},
          {1'b1, 5'd7, 64'h2222});
      idle(1);
      chk("obj3_wr_off", scene_wr_en, 1'b0);
      chk("obj3_err", err, 3'b000);

      // commit deferred by a long render, with a word during the wait
      do_reset();
      frame_busy = 1'b1;
      send(hdr(4'd2, 8'h00));
      c0 = commit_cnt;
      hi = 0;
      for (int i = 0; i < 500; i++) begin
         if (recv_interrupt || commit) hi++;
         if (i == 100) send(64'h1234);
         else idle(1);
      end
      chk("cmt_wait_hi", hi, 0);
      frame_busy = 1'b0;
      idle(1);
      chk("cmt_pulse", commit, 1'b1);
      idle(1);
      chk("cmt_once", {commit, recv_interrupt}, 2'b01);
      idle(3);
      chk("cmt_count", commit_cnt - c0, 1);
      chk("cmt_err", err, 3'b100);

      // timeout after one payload word
      do_reset();
      send(hdr(4'd1, 8'h05));
      send(64'hAAAA);
      idle(99);
      chk("to_before", err, 3'b000);
      idle(1);
      chk("to_after", err, 3'b010);
      chk("to_rint", recv_interrupt, 1'b1);
      send(hdr(4'd1, 8'h02));
      send(64'h5);
      chk("to_next", {scene_wr_en, scene_wr_addr}, {1'b1, 5'd4});
      send(64'h6);
      chk("to_next1", {scene_wr_en, scene_wr_addr}, {1'b1, 5'd5});

      // word arriving exactly on the last allowed cycle is accepted
      do_reset();
      send(hdr(4'd1, 8'h09));
      send(64'hBBBB);
      idle(98);
      send(64'hCCCC);
      chk("to_edge_wr", {scene_wr_en, scene_wr_addr, scene_wr_data},
          {1'b1, 5'd19, 64'hCCCC});
      idle(120);
      chk("to_edge_err", err, 3'b000);

      // clear: 32 zero writes, error wiped
      do_reset();
      send(64'h5A00_0000_0000_0000);
      chk("bad_sync", err, 3'b001);
      send(hdr(4'd3, 8'h00));
      for (int i = 0; i < 32; i++) begin
         chk($sformatf("clr%0d", i),
             {scene_wr_en, recv_interrupt, scene_wr_addr, scene_wr_data},
             {1'b1, 1'b0, 5'(i), 64'h0});
         idle(1);
      end
      chk("clr_done", {scene_wr_en, recv_interrupt, err}, {2'b01, 3'b000});

      // reset between payload words
      do_reset();
      send(hdr(4'd1, 8'h04));
      send(64'h4444);
      #2;
      ck_rst_ = 1'b0;
      #1;
      chk("mid_rst_out",
          {recv_interrupt, scene_wr_en, scene_wr_addr, scene_wr_data,
           commit, err},
          {1'b1, 1'b0, 5'd0, 64'h0, 1'b0, 3'b000});
      @(posedge clk);
      #1;
      ck_rst_ = 1'b1;
      idle(1);
      w0 = wr_cnt;
      send(64'h3333);
      idle(2);
      chk("mid_rst_hdr", err, 3'b001);
      chk("mid_rst_nowr", wr_cnt - w0, 0);

      // randomized traffic against a scene-array model
      do_reset();
      for (int a = 0; a < 32; a++) act_mem[a] = 64'hDEAD_BEEF_DEAD_BEEF;
      w0 = wr_cnt;
      c0 = commit_cnt;
      send(hdr(4'd3, 8'h00));
      idle(32);
      for (int a = 0; a < 32; a++) exp_mem[a] = 64'h0;
      exp_err = 3'b000;
      exp_wn  = 32;
      exp_cn  = 0;
      for (int it = 0; it < 80; it++) begin
         int kind, idx, k;
         logic [63:0] p0, p1;
         kind = $urandom_range(0, 9);
         if (kind <= 4) begin
            idx = $urandom_range(0, 15);
            p0  = {$urandom, $urandom};
            p1  = {$urandom, $urandom};
            w   = hdr(4'd1, 8'(idx));
            w[51:48] = 4'($urandom);
            w[39:0]  = {8'($urandom), $urandom};
            send(w);
            idle($urandom_range(0, 5));
            send(p0);
            idle($urandom_range(0, 5));
            send(p1);
            exp_mem[2*idx]   = p0;
            exp_mem[2*idx+1] = p1;
            exp_wn += 2;
         end else if (kind == 5) begin
            send(hdr(4'd1, 8'($urandom_range(16, 255))));
            exp_err[0] = 1'b1;
         end else if (kind == 6) begin
            w = {$urandom, $urandom};
            if (w[63:56] == 8'hA5 && w[55:52] >= 4'd1 && w[55:52] <= 4'd3)
               w[55:52] = 4'd7;
            send(w);
            exp_err[0] = 1'b1;
         end else if (kind <= 8) begin
            k = $urandom_range(0, 20);
            frame_busy = (k > 0);
            send(hdr(4'd2, 8'($urandom)));
            if (k > 0 && $urandom_range(0, 1) == 1) begin
               send({$urandom, $urandom});
               exp_err[2] = 1'b1;
               idle(k - 1);
            end else begin
               idle(k);
            end
            frame_busy = 1'b0;
            idle(1);
            chk($sformatf("rnd_commit%0d", it), commit, 1'b1);
            exp_cn++;
         end else begin
            send(hdr(4'd3, 8'($urandom)));
            idle(32);
            for (int a = 0; a < 32; a++) exp_mem[a] = 64'h0;
            exp_err = 3'b000;
            exp_wn += 32;
         end
         idle($urandom_range(0, 3));
      end
      idle(3);
      for (int a = 0; a < 32; a++)
         chk($sformatf("rnd_mem%0d", a), act_mem[a], exp_mem[a]);
      chk("rnd_err", err, exp_err);
      chk("rnd_wr_cnt", wr_cnt - w0, exp_wn);
      chk("rnd_cmt_cnt", commit_cnt - c0, exp_cn);
      chk("wr_commit_overlap", ovl_cnt, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_scene_loader.md
SPI_SCENE_LOADER -- requirements
Module: spi_scene_loader

Interface
REQ-001 Parameter OBJ_AW, default 4: object index width; 2**OBJ_AW scene objects.
REQ-002 Parameter TIMEOUT_CYCLES, default 1000000: maximum idle gap between words of one packet, in clock cycles (10 ms at 100 MHz).
REQ-003 CLK100MHZ  in  1  sole clock; all logic rising-edge.
REQ-004 ck_rst_  in  1  reset, asynchronous assert, active-low.
REQ-005 recv_dv  in  1  one-cycle strobe: recv_64bit holds a complete SPI word.
REQ-006 recv_64bit  in  64  received SPI word.
REQ-007 frame_busy  in  1  high while the raytracer is rendering; commit is deferred while high.
REQ-008 recv_interrupt  out  1  high while the block can accept a word; drives the MCU flow-control pin.
REQ-009 scene_wr_en  out  1  one-cycle scene RAM write strobe.
REQ-010 scene_wr_addr  out  OBJ_AW+1  address {object index, word offset}.
REQ-011 scene_wr_data  out  64  write data.
REQ-012 commit  out  1  one-cycle pulse: the shadow scene is complete and may be swapped.
REQ-013 err  out  3  sticky status: bit0 bad header, bit1 timeout, bit2 overrun.

Function
REQ-014 The header word SHALL have [63:56]=8'hA5, [55:52]=opcode, and [47:40]=object index; all other bits are ignored.
REQ-015 Opcodes SHALL be 1=WRITE_OBJ (two payload words follow), 2=COMMIT, and 3=CLEAR; any other opcode or sync value sets err[0] and is discarded.
REQ-016 A WRITE_OBJ whose index bits [47:40+OBJ_AW] are non-zero SHALL set err[0] and be discarded.
REQ-017 States SHALL be IDLE, PAYLOAD0, PAYLOAD1, WAIT_SWAP, and CLEARING.
REQ-018 IDLE: a valid WRITE_OBJ latches the index and moves to PAYLOAD0; COMMIT moves to WAIT_SWAP; CLEAR moves to CLEARING with the clear address set to 0.
REQ-019 PAYLOAD0/PAYLOAD1: recv_dv in cycle N SHALL give scene_wr_en=1 in cycle N+1, with address {index, 0} or {index, 1} and data equal to recv_64bit; PAYLOAD0 then moves to PAYLOAD1, and PAYLOAD1 moves to IDLE.
REQ-020 Payload words SHALL NOT be checked for the sync byte; a word equal to a header is written as data.
REQ-021 Timeout: in PAYLOAD0/1 a counter SHALL count cycles since the last accepted word; on reaching TIMEOUT_CYCLES, set err[1], return to IDLE, and suppress any write.
REQ-022 If recv_dv arrives in the same cycle the counter reaches TIMEOUT_CYCLES, the word SHALL be accepted and err[1] SHALL NOT be set.
REQ-023 WAIT_SWAP: when frame_busy is sampled low in cycle N, commit=1 in cycle N+1 and the state returns to IDLE; this is one pulse per COMMIT regardless of frame_busy duration.
REQ-024 CLEARING: the block SHALL write 64'h0 to addresses 0 through 2**(OBJ_AW+1)-1, one per cycle with scene_wr_en high, then clear err and return to IDLE.
REQ-025 recv_interrupt SHALL be 1 in IDLE, PAYLOAD0 and PAYLOAD1, 0 in WAIT_SWAP and CLEARING, and registered.
REQ-026 A recv_dv in WAIT_SWAP or CLEARING SHALL be dropped and set err[2]; the state is unaffected.
REQ-027 err bits SHALL be cleared only by reset or by completion of CLEAR.
REQ-028 scene_wr_en and commit SHALL NOT both be high in the same cycle.

Reset
REQ-029 On ck_rst_ low: state IDLE, recv_interrupt=1, scene_wr_en=0, scene_wr_addr=0, scene_wr_data=0, commit=0, err=3'b000, counters 0.
REQ-030 Reset mid-packet or mid-CLEAR SHALL abort with no further writes; the next word after release is parsed as a header.
REQ-031 Deassertion of reset SHALL take effect at a CLK100MHZ edge; the first recv_dv is accepted no earlier than 1 cycle after release.

Verification
REQ-032 Header 64'hA5_1_0_03_..., then payload 64'h1111, then payload 64'h2222 -> writes addr 6=64'h1111 and addr 7=64'h2222, each 1 cycle after its recv_dv; err=0.
REQ-033 COMMIT header while frame_busy=1 for 500 cycles -> recv_interrupt=0 throughout, exactly one commit pulse 1 cycle after frame_busy falls; a word sent during the wait -> err=3'b100.
REQ-034 WRITE_OBJ header, then 1 payload word, then no traffic (TIMEOUT_CYCLES=100) -> after 100 cycles err[1]=1 and state IDLE; the next header is decoded normally.
REQ-035 Header 64'h5A00... -> err[0]=1 and no write; WRITE_OBJ with index 8'h10 (OBJ_AW=4) -> err[0]=1 and no write.
REQ-036 CLEAR -> exactly 32 consecutive zero writes to addresses 0..31, recv_interrupt low for those 32 cycles, err=0 afterwards.
REQ-037 ck_rst_ pulsed low between payload0 and payload1 -> all outputs at reset values, and the following payload-shaped word is treated as a header (err[0]=1).
